// File: rtl/prewish_mask_blinker.sv
// Plays 8-bit blink masks MSB-first on LED_O, one bit per 2^N clocks; new masks wait in a one-deep buffer.
// Latency: ACK_O one cycle after a strobe edge; LED_O and FRAME_O registered one cycle after a tick.
// Backpressure: none; a new edge before adoption overwrites the pending mask (last write wins).
module prewish_mask_blinker #(
    parameter int BLINKY_MASK_CLK_BITS = 20
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    output logic       ACK_O,
    output logic       LED_O,
    output logic       FRAME_O
);

    logic [BLINKY_MASK_CLK_BITS-1:0] presc_q, presc_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] active_q, active_d;
    logic [7:0] pend_q, pend_d;
    logic       pend_vld_q, pend_vld_d;
    logic       stb_q, stb_d;
    logic       ack_q, ack_d;
    logic       led_q, led_d;
    logic       frame_q, frame_d;
    logic       tick;
    logic       boundary;
    logic       stb_edge;

    assign tick     = &presc_q;
    assign boundary = tick && (bit_idx_q == 3'd0);
    assign stb_edge = STB_I && !stb_q;

    always_comb begin
        presc_d    = presc_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        stb_d      = STB_I;
        ack_d      = stb_edge;
        frame_d    = 1'b0;

        if (tick) begin
            if (bit_idx_q != 3'd0) begin
                bit_idx_d = bit_idx_q - 3'd1;
            end else begin
                bit_idx_d = 3'd7;
                frame_d   = 1'b1;
                if (pend_vld_q) begin
                    active_d   = pend_q;
                    pend_vld_d = 1'b0;
                end
            end
        end

        // A colliding edge lands after the adoption above, so it stays pending for the next frame.
        if (stb_edge) begin
            pend_d     = DAT_I;
            pend_vld_d = 1'b1;
        end

        // Looking at next-state values keeps LED_O aligned with FRAME_O on the new frame's bit 7.
        led_d = active_d[bit_idx_d];
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            presc_q    <= '0;
            bit_idx_q  <= 3'd7;
            active_q   <= 8'h00;
            pend_q     <= 8'h00;
            pend_vld_q <= 1'b0;
            stb_q      <= 1'b0;
            ack_q      <= 1'b0;
            led_q      <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            bit_idx_q  <= bit_idx_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            stb_q      <= stb_d;
            ack_q      <= ack_d;
            led_q      <= led_d;
            frame_q    <= frame_d;
        end
    end

    assign ACK_O   = ack_q;
    assign LED_O   = led_q;
    assign FRAME_O = frame_q;

endmodule

// File: tb/tb_prewish_mask_blinker.sv
// Directed bench for prewish_mask_blinker with an 8-clock bit period (64-clock frame).
module tb_prewish_mask_blinker;

    logic       clk;
    logic       rst_n;
    logic       stb;
    logic [7:0] dat;
    logic       ack;
    logic       led;
    logic       frame;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int fs      = 0;

    typedef struct {
        logic [7:0] dat;
        int         hold;
        string      name;
    } vec_t;

    vec_t vecs[3];

    prewish_mask_blinker #(.BLINKY_MASK_CLK_BITS(3)) dut (
        .CLK_I   (clk),
        .RST_I   (rst_n),
        .STB_I   (stb),
        .DAT_I   (dat),
        .ACK_O   (ack),
        .LED_O   (led),
        .FRAME_O (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Steps at least once, then until FRAME_O is seen; leaves the bench on the frame-start cycle.
    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame && n < 200);
        if (!frame) chk({name, "_frame_timeout"}, 0, 1);
        fs = cyc;
    endtask

    // Called on a frame-start cycle; checks all 64 LED samples (one comparison per bit) and the next pulse.
    task automatic check_frame(input logic [7:0] mask, input string name);
        int bad;
        logic exp_bit;
        for (int b = 0; b < 8; b++) begin
            bad = 0;
            exp_bit = mask[7-b];
            for (int k = 0; k < 8; k++) begin
                if (led !== exp_bit) bad++;
                if ((b != 0 || k != 0) && frame !== 1'b0) bad++;
                step();
            end
            chk($sformatf("%s_bit%0d_bad_samples", name, 7-b), bad, 0);
        end
        chk({name, "_next_frame_pulse"}, int'(frame), 1);
        fs = cyc;
    endtask

    // Raises the strobe for hold cycles; returns number of ACK pulses and cycle of the first one.
    task automatic strobe(input logic [7:0] d, input int hold, output int acks, output int first);
        acks  = 0;
        first = -1;
        stb = 1'b1;
        dat = d;
        for (int i = 0; i < hold + 2; i++) begin
            if (i == hold) stb = 1'b0;
            step();
            if (ack) begin
                if (first < 0) first = i;
                acks++;
            end
        end
    endtask

    int acks, first;

    initial begin
        vecs[0] = '{dat: 8'hA8, hold: 1,   name: "basic_a8"};
        vecs[1] = '{dat: 8'hCA, hold: 100, name: "long_ca"};
        vecs[2] = '{dat: 8'h3C, hold: 3,   name: "short_3c"};

        rst_n = 1'b0;
        stb   = 1'b0;
        dat   = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_frame", int'(frame), 0);
        rst_n = 1'b1;
        cyc   = 0;
        wait_frame("first");
        chk("first_frame_cycle", cyc, 64);

        foreach (vecs[i]) begin
            wait_frame(vecs[i].name);
            repeat (5) step();
            strobe(vecs[i].dat, vecs[i].hold, acks, first);
            chk({vecs[i].name, "_ack_count"}, acks, 1);
            chk({vecs[i].name, "_ack_latency"}, first, 0);
            wait_frame(vecs[i].name);
            check_frame(vecs[i].dat, vecs[i].name);
            if (i == 0) check_frame(vecs[i].dat, "basic_repeat");
        end

        // Overwrite inside one frame: last write wins
        wait_frame("ovw");
        repeat (3) step();
        strobe(8'hF0, 1, acks, first);
        chk("ovw_ack1", acks, 1);
        repeat (10) step();
        strobe(8'h0F, 1, acks, first);
        chk("ovw_ack2", acks, 1);
        wait_frame("ovw");
        check_frame(8'h0F, "ovw_0f");

        // Boundary collision with pending FF: FF plays first, then 81
        repeat (3) step();
        strobe(8'hFF, 1, acks, first);
        chk("col_ack_ff", acks, 1);
        while (cyc < fs + 63) step();
        stb = 1'b1;
        dat = 8'h81;
        step();
        stb = 1'b0;
        chk("col_frame", int'(frame), 1);
        chk("col_ack_81", int'(ack), 1);
        fs = cyc;
        check_frame(8'hFF, "col_ff");
        check_frame(8'h81, "col_81");

        // Collision with empty pending: 81 repeats a full frame before 3C
        while (cyc < fs + 63) step();
        stb = 1'b1;
        dat = 8'h3C;
        step();
        stb = 1'b0;
        chk("empty_col_frame", int'(frame), 1);
        check_frame(8'h81, "empty_col_81");
        check_frame(8'h3C, "empty_col_3c");

        // Mid-frame reset with FF active and 55 pending
        strobe(8'hFF, 1, acks, first);
        wait_frame("mrst");
        repeat (10) step();
        strobe(8'h55, 1, acks, first);
        repeat (5) step();
        chk("mrst_led_before", int'(led), 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_led_async", int'(led), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        check_frame(8'h00, "mrst_frame0");
        chk("mrst_frame_cycle", cyc, 64);
        check_frame(8'h00, "mrst_frame1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
